// File: rtl/piso_serializer.sv
// Purpose : parallel-in/serial-out transmitter; accepts a WIDTH-bit word via valid/ready
//           and shifts it out one bit per enabled clock, LSB or MSB first.
// Latency : first bit on q the cycle after acceptance; done pulses one cycle after the
//           WIDTH-th enabled edge, so each word takes exactly WIDTH enabled edges.
// Backpr. : load_ready is high in IDLE or on the last-bit edge (en=1), which allows
//           back-to-back words with no gap; en=0 stalls the stream indefinitely.
//
// Ports:
//   clk        system clock, rising edge
//   reset_p    asynchronous active-high reset
//   din        parallel word, sampled when load_valid & load_ready
//   load_valid upstream word valid (held until accepted)
//   load_ready block can accept din this cycle
//   en         shift enable; stream advances only on edges with en=1
//   q          serial data bit
//   q_valid    q carries a frame bit (consumer samples on q_valid & en)
//   busy       a word is in flight (same as q_valid)
//   done       one-cycle pulse after the last bit has been consumed
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             en,
   output logic             q,
   output logic             q_valid,
   output logic             busy,
   output logic             done
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             done_q, done_d;

   logic             in_shift;
   logic             last_edge;
   logic [WIDTH-1:0] shreg_shifted;

   assign in_shift  = (state_q == SHIFT);
   // The current bit is the final one and will be consumed on this edge.
   assign last_edge = in_shift && (bit_cnt_q == LAST_CNT) && en;

   // Move the next bit toward the output end, zero-filling behind it.
   assign shreg_shifted = (LSB_FIRST != 0) ? {1'b0, shreg_q[WIDTH-1:1]}
                                           : {shreg_q[WIDTH-2:0], 1'b0};

   assign load_ready = (state_q == IDLE) || last_edge;
   assign q          = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
   assign q_valid    = in_shift;
   assign busy       = in_shift;
   assign done       = done_q;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (load_valid) begin
               shreg_d   = din;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            if (en) begin
               if (bit_cnt_q == LAST_CNT) begin
                  done_d = 1'b1;
                  if (load_valid) begin
                     // Back-to-back: next word's first bit appears next cycle.
                     shreg_d   = din;
                     bit_cnt_d = '0;
                  end else begin
                     shreg_d   = '0;
                     bit_cnt_d = '0;
                     state_d   = IDLE;
                  end
               end else begin
                  shreg_d   = shreg_shifted;
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
         end

         default: begin
            state_d   = IDLE;
            shreg_d   = '0;
            bit_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Purpose : bench for piso_serializer; an LSB-first and an MSB-first instance share stimulus.
// Latency : scoreboard expects first bit one cycle after acceptance, done one cycle after last bit.
// Backpr. : stimulus holds load_valid until load_ready; en is driven per test.
module tb_piso_serializer;

   logic       clk;
   logic       reset_p;
   logic [7:0] din;
   logic       load_valid;
   logic       en;

   logic load_ready_l, q_l, q_valid_l, busy_l, done_l;
   logic load_ready_m, q_m, q_valid_m, busy_m, done_m;

   int checks;
   int errors;

   logic       exp_lsb[$];
   logic       exp_msb[$];
   logic [7:0] exp_word[$];

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
      .clk        (clk),
      .reset_p    (reset_p),
      .din        (din),
      .load_valid (load_valid),
      .load_ready (load_ready_l),
      .en         (en),
      .q          (q_l),
      .q_valid    (q_valid_l),
      .busy       (busy_l),
      .done       (done_l)
   );

   piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
      .clk        (clk),
      .reset_p    (reset_p),
      .din        (din),
      .load_valid (load_valid),
      .load_ready (load_ready_m),
      .en         (en),
      .q          (q_m),
      .q_valid    (q_valid_m),
      .busy       (busy_m),
      .done       (done_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         exp_lsb.push_back(w[i]);
         exp_msb.push_back(w[7-i]);
      end
      exp_word.push_back(w);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word, wait for acceptance, return one step after the accepting edge.
   task automatic send(input logic [7:0] w, input bit keep_valid);
      int waited;
      din        = w;
      load_valid = 1'b1;
      push_word(w);
      waited = 0;
      @(negedge clk);
      while (!load_ready_l && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 50) chk("accept_timeout", 32'd1, 32'd0);
      tick();
      if (!keep_valid) load_valid = 1'b0;
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, "_q_l"},          q_l,          0);
      chk({tag, "_q_m"},          q_m,          0);
      chk({tag, "_q_valid"},      q_valid_l,    0);
      chk({tag, "_busy"},         busy_l,       0);
      chk({tag, "_busy_m"},       busy_m,       0);
      chk({tag, "_done"},         done_l,       0);
      chk({tag, "_load_ready"},   load_ready_l, 1);
      chk({tag, "_load_ready_m"}, load_ready_m, 1);
   endtask

   // Monitor: pops expected bits whenever the consumer would sample, rebuilds
   // the word like a downstream SIPO would, and checks done timing.
   initial begin
      int         bit_idx;
      logic       done_exp;
      logic [7:0] acc_l;
      logic [7:0] acc_m;
      logic [7:0] w;
      bit_idx  = 0;
      done_exp = 1'b0;
      acc_l    = '0;
      acc_m    = '0;
      forever begin
         @(negedge clk);
         if (reset_p) begin
            exp_lsb.delete();
            exp_msb.delete();
            exp_word.delete();
            bit_idx  = 0;
            done_exp = 1'b0;
         end else begin
            chk("done_l", done_l, done_exp);
            chk("done_m", done_m, done_exp);
            done_exp = 1'b0;
            if (q_valid_l && en) begin
               if (exp_lsb.size() == 0) begin
                  chk("unexpected_bit", 32'd1, 32'd0);
               end else begin
                  chk("q_lsb", q_l, exp_lsb.pop_front());
                  chk("q_msb", q_m, exp_msb.pop_front());
                  chk("q_valid_m", q_valid_m, 1);
                  acc_l = {q_l, acc_l[7:1]};
                  acc_m = {acc_m[6:0], q_m};
                  bit_idx++;
                  if (bit_idx == 8) begin
                     w = exp_word.pop_front();
                     chk("sipo_word_l", acc_l, w);
                     chk("sipo_word_m", acc_m, w);
                     bit_idx  = 0;
                     done_exp = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int stall_lr0;
      checks     = 0;
      errors     = 0;
      reset_p    = 1'b1;
      din        = '0;
      load_valid = 1'b0;
      en         = 1'b1;

      // Reset for two cycles, then idle outputs.
      tick();
      tick();
      reset_p = 1'b0;
      @(negedge clk);
      idle_outputs("reset");
      tick();

      // Reset mid-word at bit 3: outputs go idle asynchronously, no done follows.
      send(8'hBC, 1'b0);
      tick(); tick(); tick();
      reset_p = 1'b1;
      #1;
      idle_outputs("async_rst");
      tick();
      reset_p = 1'b0;
      repeat (3) tick();

      // Basic word: LSB 0,0,1,1,1,1,0,1 and MSB 1,0,1,1,1,1,0,0 via scoreboard.
      send(8'hBC, 1'b0);
      @(negedge clk);
      chk("first_bit_lsb", q_l, 0);
      chk("first_bit_msb", q_m, 1);
      chk("busy_first", busy_l, 1);
      repeat (10) tick();
      @(negedge clk);
      chk("basic_back_idle", q_valid_l, 0);

      // Stall after bit 2 of 8'hA5 for 5 cycles.
      tick();
      send(8'hA5, 1'b0);
      tick(); tick();
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_q_l", q_l, 1);
         chk("stall_q_m", q_m, 1);
         chk("stall_q_valid", q_valid_l, 1);
         chk("stall_load_ready", load_ready_l, 0);
         tick();
      end
      en = 1'b1;
      repeat (8) tick();

      // Back-to-back 8'hBC then 8'h3C: 16 contiguous valid bits.
      send(8'hBC, 1'b1);
      din = 8'h3C;
      push_word(8'h3C);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("b2b_q_valid", q_valid_l, 1);
         chk("b2b_load_ready", load_ready_l, ((k % 8) == 7) ? 1 : 0);
         tick();
         if (k == 7) load_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_idle", q_valid_l, 0);
      tick();

      // Ignored load mid-word: 8'hFF waits until the last-bit edge.
      send(8'h5A, 1'b0);
      tick(); tick(); tick();
      din        = 8'hFF;
      load_valid = 1'b1;
      push_word(8'hFF);
      stall_lr0  = 0;
      @(negedge clk);
      while (!load_ready_l && stall_lr0 < 20) begin
         stall_lr0++;
         @(negedge clk);
      end
      chk("ignored_load_cycles", stall_lr0, 4);
      tick();
      load_valid = 1'b0;
      din        = 8'h00;
      repeat (12) tick();

      @(negedge clk);
      chk("scoreboard_empty", exp_lsb.size(), 0);
      chk("words_empty", exp_word.size(), 0);
      idle_outputs("end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter. It is the sending end for the SISO/SIPO shift-register receivers.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out one bit per enabled clock.
- Bit order is selectable and defaults to LSB first, matching the receivers' fill order.
- Produces a serial valid strobe and a one-cycle done pulse per word, so it can drive SIPO's d/rd_en directly.

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 to 32.
- LSB_FIRST, 1, 1 = bit 0 is sent first, 0 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_p  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din is valid; held by upstream until accepted.
- load_ready  output  1  block can accept din this cycle.
- en  input  1  shift enable; the serial stream advances only on edges where en=1.
- q  output  1  serial data bit.
- q_valid  output  1  q carries a frame bit; the consumer samples when q_valid & en.
- busy  output  1  a word is in flight.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high; the reset port is reset_p and the clock port is clk.
- Internal state:
  - shreg[WIDTH-1:0].
  - bit_cnt, width $clog2(WIDTH).
  - FSM with states IDLE and SHIFT.
  - done register.
- Reset (asserted at any time, including mid-word):
  - state=IDLE, shreg=0, bit_cnt=0, done=0.
  - The in-flight word is discarded and no done pulse is issued.
  - Resulting outputs: q=0, q_valid=0, busy=0, load_ready=1.
- q:
  - Combinational from the register: shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - q_valid = busy = (state==SHIFT).
- load_ready (combinational) = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1 & en).
- IDLE:
  - On load_valid & load_ready: shreg<=din, bit_cnt<=0, go to SHIFT.
  - q is valid with the first bit in the cycle after acceptance (latency 1).
- SHIFT, en=0: hold everything; q and q_valid stay steady, with no limit on stall length.
- SHIFT, en=1, bit_cnt<WIDTH-1:
  - Shift toward the output end, zero-filling: right if LSB_FIRST, left otherwise.
  - bit_cnt<=bit_cnt+1.
- SHIFT, en=1, bit_cnt==WIDTH-1 (last bit consumed this edge):
  - done<=1 on the next cycle, for exactly one cycle.
  - If load_valid=1 (back-to-back): load din, bit_cnt<=0, stay in SHIFT. There is no gap cycle; the first bit of the new word appears the next cycle.
  - Else: shreg<=0, go to IDLE.
- load_valid in SHIFT before the last bit: ignored (load_ready=0); upstream holds din stable.
- din changing while load_ready=0 has no effect.
- done is registered and is cleared every cycle it is not being set.
- A word therefore takes exactly WIDTH enabled edges from acceptance to done.

Test Plan:
- Reset during operation:
  - Stimulus: reset_p=1 for 2 cycles, then release.
  - Response: q=0, q_valid=0, busy=0, done=0, load_ready=1. Assert reset_p mid-word at bit 3 -> outputs return to the same values immediately (asynchronously) and no done pulse follows.
- Basic LSB-first word:
  - Stimulus: LSB_FIRST=1, din=8'hBC, load_valid for 1 cycle, en=1 continuously.
  - Response: q over 8 cycles = 0,0,1,1,1,1,0,1; q_valid high for exactly 8 cycles; done pulses one cycle after the 8th bit; a SIPO fed by q/q_valid captures 8'hBC.
- MSB-first word:
  - Stimulus: LSB_FIRST=0, din=8'hBC.
  - Response: q sequence = 1,0,1,1,1,1,0,0.
- Stall:
  - Stimulus: din=8'hA5, en dropped for 5 cycles after bit 2.
  - Response: q holds bit 2 (=1) and q_valid stays 1 throughout the stall; the remaining bits resume unchanged; done is delayed by exactly 5 cycles; the total bit count remains 8.
- Back-to-back:
  - Stimulus: 8'hBC then 8'h3C, with load_valid held high and en=1.
  - Response: 16 contiguous valid bits, q_valid never drops, load_ready=1 only at the last-bit cycle, done pulses twice, 8 cycles apart.
- Ignored load:
  - Stimulus: load_valid asserted with din=8'hFF mid-word.
  - Response: load_ready=0, the in-flight word is unaffected, and 8'hFF is accepted at the last-bit edge.
